// File: rtl/gbe_txofctr_pkg.sv
// Shared constants and types for the 10GbE TX-overflow counter block.
package gbe_txofctr_pkg;

  localparam int CNT_W = 32;

  // Byte offsets from the slave window base
  localparam logic [31:0] REG_CTRL     = 32'h0000_0000;
  localparam logic [31:0] REG_SNAP     = 32'h0000_0004;
  localparam logic [31:0] REG_STATUS   = 32'h0000_0008;
  localparam logic [31:0] REG_CNT_BASE = 32'h0000_0010;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_CLEAR_BIT  = 1;
  localparam int STATUS_ANY_BIT  = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } opb_state_e;

  typedef struct packed {
    logic        rnw;
    logic [31:0] off;
  } opb_req_t;

endpackage

// File: rtl/gbe_ovf_counter.sv
// One saturating 32-bit overflow counter plus its processor-visible snapshot.
module gbe_ovf_counter
  import gbe_txofctr_pkg::*;
(
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             en,
  input  logic             evt,
  input  logic             clr,
  input  logic             snap,
  output logic [CNT_W-1:0] snap_q,
  output logic             nz
);

  logic [CNT_W-1:0] cnt_q;

  // Clear beats a same-cycle event; saturate instead of wrapping
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)                         cnt_q <= '0;
    else if (clr)                        cnt_q <= '0;
    else if (en && evt && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
  end

  // Snapshot captures the pre-increment value; CLEAR leaves it alone
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)   snap_q <= '0;
    else if (snap) snap_q <= cnt_q;
  end

  assign nz = |cnt_q;

endmodule

// File: rtl/gbe_txofctr_ctrl.sv
// Shared OPB slave for the per-core TX-overflow counters: enable/clear/snapshot
// sequencing and single-handshake snapshot reads.
module gbe_txofctr_ctrl
  import gbe_txofctr_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h010C0500,
  parameter logic [31:0] C_HIGHADDR   = 32'h010C05FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          N_PORTS      = 4
)(
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic                      Sl_xferAck,
  input  logic [N_PORTS-1:0]        ovf_event,
  output logic                      ovf_any
);

  opb_state_e state_q, state_nxt;
  opb_req_t   req_q;

  logic                            hit;
  logic [31:0]                     abus_off;
  logic [C_OPB_DWIDTH-1:0]         wdata;
  logic [29:0]                     off_w;
  logic                            xfer_ack, req_cap, wr_stb;
  logic                            ctrl_wr, snap_stb, clr_stb;
  logic                            enable_q;
  logic [31:0]                     rdata;
  logic [N_PORTS-1:0]              cnt_nz;
  logic [N_PORTS-1:0][CNT_W-1:0]   snap_q;
  logic                            unused_ok;

  assign hit      = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign abus_off = 32'(OPB_ABus) - C_BASEADDR;
  // Big-endian bus: OPB_DBus[31] lands on wdata[0]
  assign wdata    = OPB_DBus;
  assign off_w    = req_q.off[31:2];

  // ---------------- OPB FSM ----------------
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) state_q <= IDLE;
    else            state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (hit) state_nxt = ACK;
      ACK:     state_nxt = WAIT;
      WAIT:    if (!OPB_select) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_cap  = (state_q == IDLE) && hit;
    xfer_ack = (state_q == ACK);
    wr_stb   = xfer_ack && !req_q.rnw;
  end

  // Address/RNW frozen at the hit so bus changes during ACK are harmless
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n)   req_q <= '0;
    else if (req_cap) req_q <= '{rnw: OPB_RNW, off: abus_off};
  end

  // ---------------- register writes ----------------
  assign ctrl_wr  = wr_stb && (off_w == REG_CTRL[31:2]);
  assign snap_stb = wr_stb && (off_w == REG_SNAP[31:2]);
  assign clr_stb  = ctrl_wr && wdata[CTRL_CLEAR_BIT];

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n)   enable_q <= 1'b0;
    else if (ctrl_wr) enable_q <= wdata[CTRL_ENABLE_BIT];
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n)                      ovf_any <= 1'b0;
    else if (clr_stb)                    ovf_any <= 1'b0;
    else if (enable_q && (|ovf_event))   ovf_any <= 1'b1;
  end

  // ---------------- per-port counters ----------------
  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    gbe_ovf_counter u_cnt (
      .gclk   (OPB_Clk),
      .grst_n (OPB_Rst_n),
      .en     (enable_q),
      .evt    (ovf_event[i]),
      .clr    (clr_stb),
      .snap   (snap_stb),
      .snap_q (snap_q[i]),
      .nz     (cnt_nz[i])
    );
  end

  // ---------------- read mux ----------------
  always_comb begin
    rdata = '0;
    if (off_w == REG_CTRL[31:2]) begin
      rdata[CTRL_ENABLE_BIT] = enable_q;
    end else if (off_w == REG_STATUS[31:2]) begin
      rdata[N_PORTS-1:0]    = cnt_nz;
      rdata[STATUS_ANY_BIT] = ovf_any;
    end else begin
      for (int i = 0; i < N_PORTS; i++)
        if (off_w == REG_CNT_BASE[31:2] + 30'(i)) rdata = snap_q[i];
    end
  end

  assign Sl_xferAck = xfer_ack;
  assign Sl_DBus    = (xfer_ack && req_q.rnw) ? C_OPB_DWIDTH'(rdata) : '0;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign unused_ok = ^{OPB_BE, OPB_seqAddr, wdata, req_q.off[1:0]};

endmodule

// File: tb/tb_gbe_txofctr_ctrl.sv
// Directed bench for gbe_txofctr_ctrl; expected read data is queued at issue
// and checked by an independent monitor on every Sl_xferAck.
module tb_gbe_txofctr_ctrl;
  import gbe_txofctr_pkg::*;

  localparam logic [31:0] BASE = 32'h010C0500;
  localparam logic [31:0] HIGH = 32'h010C05FF;

  logic        OPB_Clk = 1'b0;
  logic        OPB_Rst_n = 1'b0;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW, OPB_select, OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck;
  logic [3:0]  ovf_event;
  logic        ovf_any;

  gbe_txofctr_ctrl dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst_n(OPB_Rst_n), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
    .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select),
    .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(Sl_DBus), .Sl_errAck(Sl_errAck),
    .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup), .Sl_xferAck(Sl_xferAck),
    .ovf_event(ovf_event), .ovf_any(ovf_any)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  typedef struct {
    logic        is_rd;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every ack consumes one scoreboard entry
  always @(negedge OPB_Clk) begin
    if (OPB_Rst_n) begin
      if (Sl_xferAck) begin
        chk("tie_offs", 32'({Sl_errAck, Sl_retry, Sl_toutSup}), 32'h0);
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ack: got ack with empty queue want none");
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.is_rd) chk(mon_e.name, Sl_DBus, mon_e.exp);
        end
      end else begin
        chk("dbus_idle", Sl_DBus, 32'h0);
      end
    end
  end

  // One OPB transfer; ev_ack is held on ovf_event for the two cycles after ack
  task automatic bus(input logic rnw, input logic [31:0] off, input logic [31:0] data,
                     input logic [31:0] exp, input string nm, input logic [3:0] ev_ack,
                     output logic any_mid);
    int lat;
    sb.push_back('{rnw, exp, nm});
    OPB_ABus   = BASE + off;
    OPB_RNW    = rnw;
    OPB_DBus   = rnw ? 32'h0 : data;
    OPB_select = 1'b1;
    lat = 0;
    do begin
      @(negedge OPB_Clk);
      lat++;
    end while (!Sl_xferAck && lat < 8);
    total++;
    if (lat != 1 || !Sl_xferAck) begin
      bad++;
      $display("FAIL %s_latency: got %0d cycles want 1", nm, lat);
      if (!Sl_xferAck) void'(sb.pop_back());
    end
    OPB_select = 1'b0;
    ovf_event  = ev_ack;
    @(negedge OPB_Clk);
    any_mid = ovf_any;
    @(negedge OPB_Clk);
    ovf_event = '0;
  endtask

  task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string nm);
    logic am;
    bus(1'b1, off, 32'h0, exp, nm, 4'b0000, am);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] data, input string nm);
    logic am;
    bus(1'b0, off, data, 32'h0, nm, 4'b0000, am);
  endtask

  task automatic pulse(input logic [3:0] ev, input int n);
    ovf_event = ev;
    repeat (n) @(negedge OPB_Clk);
    ovf_event = '0;
  endtask

  task automatic no_ack(input logic [31:0] addr, input string nm);
    logic seen;
    seen = 1'b0;
    OPB_ABus = addr; OPB_RNW = 1'b1; OPB_select = 1'b1;
    repeat (3) begin
      @(negedge OPB_Clk);
      seen |= Sl_xferAck;
    end
    chk(nm, 32'(seen), 32'h0);
    OPB_select = 1'b0;
    @(negedge OPB_Clk);
  endtask

  initial begin
    logic am;
    OPB_ABus = '0; OPB_BE = 4'hF; OPB_DBus = '0; OPB_RNW = 1'b1;
    OPB_select = 1'b0; OPB_seqAddr = 1'b0; ovf_event = '0;
    repeat (3) @(negedge OPB_Clk);
    chk("rst_any",   32'(ovf_any),     32'h0);
    chk("rst_ack",   32'(Sl_xferAck),  32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    OPB_Rst_n = 1'b1;
    @(negedge OPB_Clk);

    // Reset values through the bus
    rd(REG_CTRL,   32'h0, "rd_ctrl_rst");
    rd(REG_STATUS, 32'h0, "rd_status_rst");

    // Events while disabled are ignored
    pulse(4'b0001, 10);
    chk("any_disabled", 32'(ovf_any), 32'h0);
    wr(REG_SNAP, 32'h0, "wr_snap_dis");
    rd(32'h10, 32'h0, "rd_cnt0_dis");
    rd(REG_STATUS, 32'h0, "rd_status_dis");

    // Enable, five events on port 2; snap with concurrent events takes pre-increment value
    wr(REG_CTRL, 32'h1, "wr_enable");
    pulse(4'b0100, 5);
    bus(1'b0, REG_SNAP, 32'h0, 32'h0, "wr_snap_ev", 4'b0100, am);
    rd(32'h18, 32'h5, "rd_cnt2");
    rd(32'h10, 32'h0, "rd_cnt0");
    rd(REG_STATUS, 32'h8000_0004, "rd_status_p2");
    rd(REG_CTRL, 32'h1, "rd_ctrl_en");
    rd(REG_SNAP, 32'h0, "rd_snap_reg");
    rd(32'h0C, 32'h0, "rd_hole_0c");
    rd(32'h20, 32'h0, "rd_past_ports");
    rd(HIGH - BASE - 32'h3, 32'h0, "rd_top_word");
    no_ack(BASE - 32'h4, "no_ack_below");
    no_ack(HIGH + 32'h1, "no_ack_above");

    // Saturation on port 1 from FFFFFFFE with three events
    @(negedge OPB_Clk);
    force dut.g_port[1].u_cnt.cnt_q = 32'hFFFF_FFFE;
    ovf_event = 4'b0010;
    @(negedge OPB_Clk);
    release dut.g_port[1].u_cnt.cnt_q;
    repeat (2) @(negedge OPB_Clk);
    ovf_event = '0;
    wr(REG_SNAP, 32'h0, "wr_snap_sat");
    rd(32'h14, 32'hFFFF_FFFF, "rd_cnt1_sat");
    rd(REG_STATUS, 32'h8000_0006, "rd_status_sat");

    // CLEAR with a same-cycle event on port 0, then one counted event
    bus(1'b0, REG_CTRL, 32'h3, 32'h0, "wr_clear", 4'b0001, am);
    chk("any_after_clear", 32'(am), 32'h0);
    chk("any_after_event", 32'(ovf_any), 32'h1);
    rd(32'h18, 32'h7, "rd_snap_kept");
    wr(REG_SNAP, 32'h0, "wr_snap_clr");
    rd(32'h10, 32'h1, "rd_cnt0_clr");
    rd(32'h14, 32'h0, "rd_cnt1_clr");
    rd(32'h18, 32'h0, "rd_cnt2_clr");
    rd(REG_STATUS, 32'h8000_0001, "rd_status_clr");
    rd(REG_CTRL, 32'h1, "rd_ctrl_clr");

    // Reset while in WAIT
    sb.push_back('{1'b1, 32'h1, "rd_ctrl_pre_rst"});
    OPB_ABus = BASE; OPB_RNW = 1'b1; OPB_select = 1'b1;
    @(negedge OPB_Clk);
    chk("ack_pre_rst", 32'(Sl_xferAck), 32'h1);
    @(negedge OPB_Clk);
    chk("in_wait", 32'(dut.state_q), 32'(WAIT));
    #1 OPB_Rst_n = 1'b0;
    #1;
    chk("rst_wait_ack",   32'(Sl_xferAck),  32'h0);
    chk("rst_wait_state", 32'(dut.state_q), 32'(IDLE));
    OPB_select = 1'b0;
    repeat (2) @(negedge OPB_Clk);
    OPB_Rst_n = 1'b1;
    @(negedge OPB_Clk);

    // Reset while in ACK drops the ack immediately
    sb.push_back('{1'b1, 32'h0, "rd_status_ack_rst"});
    OPB_ABus = BASE + REG_STATUS; OPB_select = 1'b1;
    @(negedge OPB_Clk);
    #1 OPB_Rst_n = 1'b0;
    #1;
    chk("rst_ack_ack",   32'(Sl_xferAck),  32'h0);
    chk("rst_ack_state", 32'(dut.state_q), 32'(IDLE));
    OPB_select = 1'b0;
    repeat (2) @(negedge OPB_Clk);
    OPB_Rst_n = 1'b1;
    @(negedge OPB_Clk);

    rd(REG_CTRL,   32'h0, "rd_ctrl_post_rst");
    rd(REG_STATUS, 32'h0, "rd_status_post_rst");
    rd(32'h10,     32'h0, "rd_snap0_post_rst");
    chk("any_post_rst", 32'(ovf_any), 32'h0);

    repeat (2) @(negedge OPB_Clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gbe_txofctr_ctrl.md
Name: gbe_txofctr_ctrl

Overview:
Control and scheduling block for the 10GbE TX-overflow counters. It owns N_PORTS per-core saturating overflow counters and a single OPB slave window. It sequences the enable, clear and snapshot operations, and serves processor reads of the snapshot registers with one OPB handshake. It sits on the OPB bus beside the per-core GbE status registers and replaces one register slave per core with one shared slave.

Parameters:
C_BASEADDR, 32'h010C0500, first byte address of the slave window
C_HIGHADDR, 32'h010C05FF, last byte address of the slave window
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width
N_PORTS, 4, number of GbE cores monitored (1..8)

Ports:
OPB_Clk  in  1  single clock; all logic runs on it
OPB_Rst_n  in  1  asynchronous, active-low reset
OPB_ABus  in  [0:31]  OPB address, bit 0 = MSB
OPB_BE  in  [0:3]  byte enables; ignored, all accesses are full-word
OPB_DBus  in  [0:31]  OPB write data, bit 31 = LSB
OPB_RNW  in  1  1 = read, 0 = write
OPB_select  in  1  OPB transfer request
OPB_seqAddr  in  1  ignored
Sl_DBus  out  [0:31]  read data; zero whenever Sl_xferAck = 0
Sl_errAck  out  1  tied 0
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
Sl_xferAck  out  1  transfer acknowledge, one-cycle pulse
ovf_event  in  N_PORTS  per-core TX overflow strobe; one count per cycle high
ovf_any  out  1  sticky flag: some enabled event since the last clear

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FSM goes to IDLE.
  - All counters and snapshots are 0.
  - ENABLE = 0, ovf_any = 0, Sl_xferAck = 0, Sl_DBus = 0.
- Register map, byte offsets from C_BASEADDR. LSB = OPB_DBus[31].
  - 0x00 CTRL, read/write. Bit 0 = ENABLE. Bit 1 = CLEAR, write-1 pulse that self-clears and always reads 0.
  - 0x04 SNAP, write-only. Any write latches all counters into the snapshots. Reads return 0.
  - 0x08 STATUS, read-only. Bits [N_PORTS-1:0] = per-port nonzero-counter flags. Bit 31 = ovf_any.
  - 0x10 + 4*i, read-only: snapshot of port i, for i < N_PORTS.
  - Any other in-window offset reads 0 and ignores writes.
- Hit = OPB_select AND C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
- OPB FSM:
  - IDLE -> ACK on a hit.
  - ACK -> WAIT unconditionally. In ACK, Sl_xferAck = 1 and Sl_DBus carries the read data; register write side effects also happen in this cycle.
  - WAIT -> IDLE when OPB_select = 0, otherwise stay in WAIT.
  - Latency from select to ack is one cycle. No back-to-back ack without select deasserting first.
- Address and RNW are registered in IDLE on the hit. A change in ACK has no effect.
- Counter i:
  - Increments by 1 in each cycle where ENABLE = 1 and ovf_event[i] = 1.
  - Saturates at 32'hFFFFFFFF; no wrap.
  - Increments are ignored while ENABLE = 0.
- Simultaneous events:
  - CLEAR and an event in the same cycle: counter = 0, ovf_any = 0, CLEAR wins.
  - SNAP and an event in the same cycle: the snapshot takes the pre-increment value and the counter increments.
  - CLEAR and ENABLE written together: the clear applies and the new ENABLE value takes effect.
  - CLEAR does not clear snapshots.
- ovf_any sets on any counted event and clears only on CLEAR or reset.
- Reset during ACK or WAIT: FSM returns to IDLE and Sl_xferAck drops immediately (asynchronous).

Decomposition:
- Package gbe_txofctr_pkg holds:
  - register offsets REG_CTRL, REG_SNAP, REG_STATUS, REG_CNT_BASE;
  - CTRL bit indices;
  - the FSM state enum {IDLE, ACK, WAIT}.
- Sub-module gbe_ovf_counter: one 32-bit saturating counter with enable, clear and snapshot register. Instantiated N_PORTS times by a generate loop.

Test Plan:
1. Reset, then read 0x00 -> ack exactly 1 cycle after select, data 0. Sl_errAck, Sl_retry and Sl_toutSup stay 0.
2. Write CTRL = 1; pulse ovf_event[2] for 5 cycles; write SNAP; read 0x18 -> 5. Read 0x10 -> 0. STATUS -> 32'h80000004.
3. With ENABLE = 0, pulse ovf_event[0] for 10 cycles; snap; read 0x10 -> 0. ovf_any stays 0.
4. Force counter 1 to 32'hFFFFFFFE; give 3 events; snap; read 0x14 -> 32'hFFFFFFFF.
5. Same cycle: CLEAR write (CTRL = 3) with ovf_event[0] high -> counter 0 = 0 and ovf_any = 0. Next-cycle event -> counter 0 = 1.
6. Assert OPB_Rst_n low while in WAIT -> Sl_xferAck = 0 and FSM in IDLE. After release, a fresh select is acked normally.
